// File: rtl/nes_pad_pkg.sv
// Shared types and default constants for the NES/SNES controller poller.
package nes_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_NUM_PADS = 2;
    localparam int DEF_NUM_BITS = 8;
    localparam int DEF_CLK_DIV  = 6;

endpackage

// File: rtl/nes_pad_shift.sv
// Per-pad capture register: bits arrive first-bit-first and settle LSB-first.
module nes_pad_shift
    import nes_pad_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                sample,
    input  logic                data,
    output logic [NUM_BITS-1:0] bits
);

    // Pad data is active-low; invert on entry so stored ones mean "pressed".
    always_ff @(posedge clk) begin
        if (clear) begin
            bits <= '0;
        end else if (sample) begin
            bits <= {~data, bits[NUM_BITS-1:1]};
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls NUM_PADS serial game pads in parallel and publishes debounced-free
// button snapshots plus press/release edges once per completed poll.
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int NUM_PADS = DEF_NUM_PADS,
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         pad_latch,
    output logic                         pad_clk,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released,
    output logic                         valid,
    output logic [2:0]                   fsm_state
);

    localparam int DIV_W = $clog2(2*CLK_DIV+1);
    localparam int BIT_W = $clog2(NUM_BITS+1);
    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2*CLK_DIV-1);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV-1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS-1);

    state_t                      state;
    logic [DIV_W-1:0]            div_cnt;
    logic [BIT_W-1:0]            bit_cnt;
    logic                        sample;
    logic                        shift_clear;
    logic [NUM_PADS*NUM_BITS-1:0] capture;

    assign fsm_state   = state;
    assign shift_clear = reset || (state == ST_IDLE && start);
    assign sample      = (state == ST_LATCH  && div_cnt == LATCH_LAST) ||
                         (state == ST_CLK_HI && div_cnt == HALF_LAST);

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        nes_pad_shift #(.NUM_BITS(NUM_BITS)) u_shift (
            .clk    (clk),
            .clear  (shift_clear),
            .sample (sample),
            .data   (pad_data[p]),
            .bits   (capture[p*NUM_BITS +: NUM_BITS])
        );
    end

    // Outputs are registered alongside the state transition that implies them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            valid     <= 1'b0;
            buttons   <= '0;
            pressed   <= '0;
            released  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LATCH;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        pad_latch <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt == LATCH_LAST) begin
                        state     <= ST_CLK_LO;
                        div_cnt   <= '0;
                        bit_cnt   <= BIT_W'(1);
                        pad_latch <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_CLK_LO: begin
                    if (div_cnt == HALF_LAST) begin
                        state   <= ST_CLK_HI;
                        div_cnt <= '0;
                        pad_clk <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_CLK_HI: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        pad_clk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_CLK_LO;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    valid    <= 1'b1;
                    buttons  <= capture;
                    pressed  <= capture & ~buttons;
                    released <= ~capture & buttons;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nes_pad_reader.md
NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2, number of controller ports polled in parallel (1..4).
REQ-002 SHALL have parameter NUM_BITS, default 8, serial bits per controller (8 for NES, 16 for SNES; range 2..16).
REQ-003 SHALL have parameter CLK_DIV, default 6, clk cycles per half-period of pad_clk (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, poll request; sampled only in IDLE.
REQ-007 SHALL have port busy, output, 1, high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when a poll completes.
REQ-009 SHALL have port pad_latch, output, 1, shared parallel-load strobe to all pads.
REQ-010 SHALL have port pad_clk, output, 1, shared shift clock to all pads.
REQ-011 SHALL have port pad_data, input, NUM_PADS, active-low serial data, one bit per pad.
REQ-012 SHALL have port buttons, output, NUM_PADS*NUM_BITS, active-high button state; pad p occupies bits [p*NUM_BITS +: NUM_BITS].
REQ-013 SHALL have ports pressed and released, output, NUM_PADS*NUM_BITS each, same layout as buttons.
REQ-014 SHALL have port valid, output, 1, high once any poll has completed since reset.

Function
REQ-015 SHALL implement states IDLE, LATCH, CLK_LO, CLK_HI, DONE.
REQ-016 IDLE: start=1 -> LATCH next cycle; start=0 -> stay; start outside IDLE is ignored, not queued.
REQ-017 LATCH: pad_latch=1 for 2*CLK_DIV cycles; bit 0 of every pad sampled in the last LATCH cycle; then -> CLK_LO.
REQ-018 CLK_LO: pad_clk=0, pad_latch=0 for CLK_DIV cycles; then -> CLK_HI.
REQ-019 CLK_HI: pad_clk=1 for CLK_DIV cycles; next bit sampled in last CLK_HI cycle; after bit NUM_BITS-1 -> DONE, else -> CLK_LO.
REQ-020 Bit k (k=0 first) SHALL land in pad-local bit k; stored value is ~pad_data (inversion applied at sample).
REQ-021 DONE: one cycle; done=1; buttons, pressed, released, valid update in this cycle (visible the following cycle); -> IDLE.
REQ-022 pressed = new & ~old buttons; released = ~new & old; both held until the next DONE.
REQ-023 Latency: start accepted in cycle 0 -> done high in cycle NUM_BITS*2*CLK_DIV+1.
REQ-024 buttons SHALL NOT change mid-poll; partial results live only in internal shift registers.
REQ-025 Back-to-back: start high in the cycle after DONE starts the next poll immediately; done is never wider than one cycle.
REQ-026 Unconnected pad (pad_data held 1) SHALL read as all buttons released.
REQ-027 Divider counter width SHALL be $clog2(2*CLK_DIV+1); bit counter width $clog2(NUM_BITS+1).

Reset
REQ-028 On reset: state IDLE; busy, done, pad_latch, pad_clk, valid = 0; buttons, pressed, released and shift registers = 0.
REQ-029 Reset mid-poll SHALL abort immediately (pad_latch/pad_clk low the next cycle) with no done pulse; reset dominates start.

Structure
REQ-030 Shared package nes_pad_pkg SHALL hold the state enum type and default parameter constants.
REQ-031 Per-pad capture SHALL be one sub-module nes_pad_shift (NUM_BITS shift register with sample enable and clear), instantiated NUM_PADS times by generate.

Verification
REQ-032 NUM_PADS=2, NUM_BITS=8, CLK_DIV=2; pad0 serial 0,1,1,1,1,1,1,1, pad1 all 1 -> done in cycle 33, buttons[7:0]=0x01, buttons[15:8]=0x00, pressed[7:0]=0x01.
REQ-033 Repeat poll, pad0 now all 1 -> buttons[7:0]=0x00, released[7:0]=0x01, pressed=0.
REQ-034 Waveform check CLK_DIV=2: pad_latch high exactly 4 cycles, then 7 pad_clk pulses each 2 low + 2 high, pad_clk low at idle.
REQ-035 start pulsed in cycles 5 and 20 during a poll -> exactly one done; subsequent poll only on a new start in IDLE.
REQ-036 reset asserted in cycle 10 of a poll -> next cycle all outputs 0, state IDLE, no done; following poll completes normally.
REQ-037 NUM_BITS=16, NUM_PADS=1, CLK_DIV=1, alternating serial 0,1 -> buttons=0x5555, done in cycle 33.
